lockstep_ctrl_bank: RTL and testbench
=====================================

Name: lockstep_ctrl_bank

Overview:
Parametrised successor of the single-register lockstep control peripheral. It holds per-core-pair lockstep enables that the software stages and a barrier commits. It also counts per-pair lockstep mismatches, keeps sticky error status and raises a maskable interrupt. It sits on the cluster peripheral interconnect (req/gnt, one-cycle response) at BASE_ADDR and drives lockstep_mode_o to the core-pair comparators.

Parameters:
ID_WIDTH, 5, width of transaction ID echoed on response.
N_PAIRS, 4, number of lockstep core pairs (1..32).
N_BARRIERS, 8, width of barrier_matched_i.
COMMIT_BAR, 0, index of barrier bit that commits staged CTRL into ACTIVE.
CNT_WIDTH, 16, width of each saturating mismatch counter (1..32).
BASE_ADDR, 32'h10202400, byte address of register 0.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  1  bus request
addr_i  in  32  byte address
wen_i  in  1  1 = read, 0 = write
wdata_i  in  32  write data
be_i  in  4  byte enables (writes only)
id_i  in  ID_WIDTH  transaction ID
gnt_o  out  1  grant, constant 1
r_valid_o  out  1  response valid
r_opc_o  out  1  1 = error (unmapped address)
r_id_o  out  ID_WIDTH  echoed ID
r_rdata_o  out  32  read data
barrier_matched_i  in  N_BARRIERS  barrier match vector from event unit
mismatch_i  in  N_PAIRS  per-pair comparator mismatch, one pulse per cycle counted
lockstep_mode_o  out  N_PAIRS  applied lockstep enable per pair (= ACTIVE)
irq_o  out  1  error interrupt, registered

Behaviour:
- Register map (offset from BASE_ADDR, word aligned, bits above N_PAIRS read 0):
  - 0x00 CTRL, RW: staged enables.
  - 0x04 ACTIVE, RO: applied enables.
  - 0x08 STATUS, RW1C: sticky mismatch flags.
  - 0x0C IRQ_EN, RW.
  - 0x10+4*i CNT[i], i<N_PAIRS: mismatch count, zero-extended; any write clears it.
- Mapped test: addr_i equals BASE_ADDR+offset exactly.
- Reset: all registers 0; r_valid_o=0, r_opc_o=0, r_id_o=0, r_rdata_o=0, irq_o=0, lockstep_mode_o=0.
- Bus handshake:
  - gnt_o=1 combinationally.
  - Every accepted req_i gives exactly one response on the next cycle: r_valid_o=1, r_id_o=id_i of that request.
  - Back-to-back requests give back-to-back responses.
- Reads: r_rdata_o is registered from register values in the request cycle, so updates made in the same cycle are not visible.
- Writes: apply at the clock edge ending the request cycle, respecting be_i per byte for CTRL, IRQ_EN and STATUS (W1C per enabled byte). r_rdata_o=0 on write responses.
- Unmapped address, read or write: no state change, r_opc_o=1, r_rdata_o=0. Otherwise r_opc_o=0.
- With no response pending: r_valid_o=0, r_opc_o=0, r_rdata_o=0; r_id_o holds its last value.
- Commit: each cycle barrier_matched_i[COMMIT_BAR]=1, ACTIVE <= CTRL (level-sensitive; other bits ignored). A CTRL write in the same cycle is not committed; ACTIVE takes the pre-write CTRL.
- Mismatch, per pair i:
  - Counted only if ACTIVE[i]=1 in that cycle: CNT[i] increments, saturating at 2^CNT_WIDTH-1, and STATUS[i] sets.
  - Mismatch while ACTIVE[i]=0 is ignored.
- Simultaneous events:
  - STATUS W1C and a new mismatch on the same bit: set wins (bit stays 1).
  - CNT[i] write-clear and a counted mismatch: CNT[i] becomes 1.
- irq_o <= |(STATUS & IRQ_EN), registered one cycle after the STATUS/IRQ_EN update.
- Reset asserted mid-transaction: the pending response is dropped and all state returns to reset values asynchronously.

Test Plan:
- Reset, then read 0x04 and CNT[3] (0x1C) -> r_valid_o one cycle later, rdata 0, r_opc_o=0, id echoed; lockstep_mode_o=0.
- Write CTRL=0x5, be=0xF; no barrier -> read ACTIVE=0x0. Pulse barrier_matched_i=8'h01 for 1 cycle -> lockstep_mode_o=4'b0101 next cycle, read ACTIVE=0x5.
- ACTIVE=0x5; pulse mismatch_i=4'b0011 3 cycles -> CNT[0]=3, CNT[1]=0, STATUS=0x1. Set IRQ_EN=0x1 -> irq_o=1. Write STATUS=0x1 -> irq_o=0 two cycles later.
- CNT_WIDTH=4, 20 mismatch cycles on pair 0 -> CNT[0]=15 (saturated). Write 0x14? No: write CNT[0] in the same cycle as a mismatch -> CNT[0]=1.
- Write STATUS W1C bit0 in the same cycle as mismatch_i[0]=1 (ACTIVE[0]=1) -> STATUS[0] stays 1.
- Read BASE_ADDR+0x40 with N_PAIRS=4 -> r_opc_o=1, rdata 0. Write CTRL=0xFF with be=4'b0000 -> CTRL unchanged. Back-to-back reqs id=3 then id=7 -> responses in consecutive cycles, ids 3 then 7.

Source files
------------

// File: rtl/lockstep_ctrl_bank.sv
// ---------------------------------------------------------------------------
// lockstep_ctrl_bank
//
// Lockstep control peripheral for a bank of core pairs. Software stages
// per-pair lockstep enables in CTRL. Each cycle the commit barrier bit is
// high, CTRL is copied into ACTIVE, which drives the pair comparators.
// Comparator mismatches on active pairs bump a saturating per-pair counter
// and set a sticky STATUS flag. Any STATUS flag that is also enabled in
// IRQ_EN raises the registered interrupt.
//
// Register map (byte offsets from BASE_ADDR, word aligned):
//   0x00        CTRL    RW    staged enables
//   0x04        ACTIVE  RO    applied enables
//   0x08        STATUS  RW1C  sticky mismatch flags
//   0x0C        IRQ_EN  RW    interrupt enables
//   0x10+4*i    CNT[i]  RO    mismatch count; any write clears it
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_i .. id_i       peripheral bus request (wen_i = 1 means read)
//   gnt_o               always granted
//   r_valid_o .. r_rdata_o  one-cycle-later response
//   barrier_matched_i   barrier vector; bit COMMIT_BAR commits CTRL
//   mismatch_i          per-pair comparator mismatch
//   lockstep_mode_o     applied enables (ACTIVE)
//   irq_o               registered error interrupt
// ---------------------------------------------------------------------------
module lockstep_ctrl_bank #(
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned N_PAIRS    = 4,
    parameter int unsigned N_BARRIERS = 8,
    parameter int unsigned COMMIT_BAR = 0,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h10202400
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [31:0]           addr_i,
    input  logic                  wen_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic                  r_opc_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [31:0]           r_rdata_o,
    input  logic [N_BARRIERS-1:0] barrier_matched_i,
    input  logic [N_PAIRS-1:0]    mismatch_i,
    output logic [N_PAIRS-1:0]    lockstep_mode_o,
    output logic                  irq_o
);

    // Four fixed registers followed by one counter per pair.
    localparam int unsigned N_REGS = 4 + N_PAIRS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] offset;
    logic [29:0] word_idx;
    logic        mapped;
    logic        wr_en;
    logic        rd_en;

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    assign offset   = addr_i - BASE_ADDR;
    assign word_idx = offset[31:2];
    assign mapped   = (offset[1:0] == 2'b00) && (word_idx < 30'(N_REGS));
    assign wr_en    = req_i && !wen_i && mapped;
    assign rd_en    = req_i &&  wen_i && mapped;

    logic wr_ctrl;
    logic wr_status;
    logic wr_irq_en;
    logic [N_PAIRS-1:0] wr_cnt;

    assign wr_ctrl   = wr_en && (word_idx == 30'd0);
    assign wr_status = wr_en && (word_idx == 30'd2);
    assign wr_irq_en = wr_en && (word_idx == 30'd3);

    always_comb begin
        for (int i = 0; i < N_PAIRS; i++) begin
            wr_cnt[i] = wr_en && (word_idx == 30'(4 + i));
        end
    end

    // Per-bit write mask: bit i belongs to byte lane i/8.
    logic [N_PAIRS-1:0] be_mask;
    always_comb begin
        for (int i = 0; i < N_PAIRS; i++) begin
            be_mask[i] = be_i[i / 8];
        end
    end

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [N_PAIRS-1:0]   ctrl_q;
    logic [N_PAIRS-1:0]   active_q;
    logic [N_PAIRS-1:0]   status_q;
    logic [N_PAIRS-1:0]   irq_en_q;
    logic [CNT_WIDTH-1:0] cnt_q [N_PAIRS];

    logic [N_PAIRS-1:0]   counted;
    logic [N_PAIRS-1:0]   status_clr;
    logic [N_PAIRS-1:0]   status_d;
    logic [CNT_WIDTH-1:0] cnt_d [N_PAIRS];

    // A mismatch only matters on a pair that is running in lockstep now.
    assign counted = mismatch_i & active_q;

    // Set dominates clear so a mismatch racing the W1C is never lost.
    assign status_clr = wr_status ? (wdata_i[N_PAIRS-1:0] & be_mask) : '0;
    assign status_d   = (status_q & ~status_clr) | counted;

    // NOTE: every output of a combinational block gets a default before any
    // conditional logic; a path that leaves it unassigned infers a latch.
    always_comb begin
        for (int i = 0; i < N_PAIRS; i++) begin
            cnt_d[i] = wr_cnt[i] ? '0 : cnt_q[i];
            if (counted[i] && (cnt_d[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_d[i] + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what makes a commit take the
    // CTRL value from before a same-cycle write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            active_q <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= (ctrl_q & ~be_mask) | (wdata_i[N_PAIRS-1:0] & be_mask);
            end
            if (wr_irq_en) begin
                irq_en_q <= (irq_en_q & ~be_mask) | (wdata_i[N_PAIRS-1:0] & be_mask);
            end
            if (barrier_matched_i[COMMIT_BAR]) begin
                active_q <= ctrl_q;
            end
            status_q <= status_d;
            irq_o    <= |(status_q & irq_en_q);
        end
    end

    // NOTE: the counter array is reset like any other register because
    // software reads it directly and expects zero after reset; it is a small
    // flop array, not a RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_PAIRS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PAIRS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (register values as they stand in the request cycle)
    // ------------------------------------------------------------------
    logic [31:0] rdata_mux;
    always_comb begin
        rdata_mux = '0;
        case (word_idx)
            30'd0:   rdata_mux = 32'(ctrl_q);
            30'd1:   rdata_mux = 32'(active_q);
            30'd2:   rdata_mux = 32'(status_q);
            30'd3:   rdata_mux = 32'(irq_en_q);
            default: begin
                for (int i = 0; i < N_PAIRS; i++) begin
                    if (word_idx == 30'(4 + i)) begin
                        rdata_mux = 32'(cnt_q[i]);
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response channel
    // ------------------------------------------------------------------
    assign gnt_o = 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_opc_o   <= 1'b0;
            r_id_o    <= '0;
            r_rdata_o <= '0;
        end else begin
            r_valid_o <= req_i;
            r_opc_o   <= req_i && !mapped;
            r_rdata_o <= rd_en ? rdata_mux : 32'd0;
            if (req_i) begin
                r_id_o <= id_i;
            end
        end
    end

    assign lockstep_mode_o = active_q;

    // Bits that exist on the port but carry no function for this N_PAIRS.
    logic unused_bits;
    assign unused_bits = ^{wdata_i, be_i, barrier_matched_i};

endmodule

// File: tb/tb_lockstep_ctrl_bank.sv
// ---------------------------------------------------------------------------
// tb_lockstep_ctrl_bank
//
// Directed bench with a response scoreboard. The stimulus thread pushes the
// hand-computed expected response for every bus request; an independent
// monitor pops and compares whenever r_valid_o is seen, and also checks that
// a response appears exactly one cycle after every request. Side-band outputs
// (lockstep_mode_o, irq_o) are checked directly by the stimulus thread.
// CNT_WIDTH is reduced to 4 so counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_lockstep_ctrl_bank;

    localparam int unsigned ID_WIDTH   = 5;
    localparam int unsigned N_PAIRS    = 4;
    localparam int unsigned N_BARRIERS = 8;
    localparam int unsigned CNT_WIDTH  = 4;
    localparam logic [31:0] BASE       = 32'h10202400;

    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_ACTIVE = BASE + 32'h04;
    localparam logic [31:0] A_STATUS = BASE + 32'h08;
    localparam logic [31:0] A_IRQEN  = BASE + 32'h0C;
    localparam logic [31:0] A_CNT0   = BASE + 32'h10;
    localparam logic [31:0] A_CNT1   = BASE + 32'h14;
    localparam logic [31:0] A_CNT2   = BASE + 32'h18;
    localparam logic [31:0] A_CNT3   = BASE + 32'h1C;

    logic                  clk;
    logic                  rst_n;
    logic                  req;
    logic [31:0]           addr;
    logic                  wen;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic [ID_WIDTH-1:0]   id;
    logic                  gnt;
    logic                  r_valid;
    logic                  r_opc;
    logic [ID_WIDTH-1:0]   r_id;
    logic [31:0]           r_rdata;
    logic [N_BARRIERS-1:0] barrier;
    logic [N_PAIRS-1:0]    mismatch;
    logic [N_PAIRS-1:0]    mode;
    logic                  irq;

    lockstep_ctrl_bank #(
        .ID_WIDTH   (ID_WIDTH),
        .N_PAIRS    (N_PAIRS),
        .N_BARRIERS (N_BARRIERS),
        .COMMIT_BAR (0),
        .CNT_WIDTH  (CNT_WIDTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_i             (req),
        .addr_i            (addr),
        .wen_i             (wen),
        .wdata_i           (wdata),
        .be_i              (be),
        .id_i              (id),
        .gnt_o             (gnt),
        .r_valid_o         (r_valid),
        .r_opc_o           (r_opc),
        .r_id_o            (r_id),
        .r_rdata_o         (r_rdata),
        .barrier_matched_i (barrier),
        .mismatch_i        (mismatch),
        .lockstep_mode_o   (mode),
        .irq_o             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ID_WIDTH-1:0] id;
        logic                opc;
        logic [31:0]         rdata;
    } exp_t;

    exp_t exp_q[$];

    // ------------------------------------------------------------------
    // Monitor: response must follow each request by exactly one cycle.
    // ------------------------------------------------------------------
    logic req_seen;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_seen <= 1'b0;
        else        req_seen <= req;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_seen || r_valid) begin
                check("r_valid_timing", 32'(r_valid), 32'(req_seen));
            end
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'(r_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("r_id",    32'(r_id),  32'(e.id));
                    check("r_opc",   32'(r_opc), 32'(e.opc));
                    check("r_rdata", r_rdata,    e.rdata);
                    check("gnt",     32'(gnt),   32'd1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic is_rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [ID_WIDTH-1:0] i,
                       input logic exp_opc, input logic [31:0] exp_rdata);
        exp_t e;
        req   = 1'b1;
        wen   = is_rd;
        addr  = a;
        wdata = d;
        be    = b;
        id    = i;
        e.id    = i;
        e.opc   = exp_opc;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req   = 1'b0;
        wen   = 1'b1;
        addr  = '0;
        wdata = '0;
        be    = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [ID_WIDTH-1:0] i, input logic [31:0] exp);
        bus(1'b1, a, 32'd0, 4'h0, i, 1'b0, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic [ID_WIDTH-1:0] i);
        bus(1'b0, a, d, b, i, 1'b0, 32'd0);
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b1;
        req      = 1'b0;
        wen      = 1'b1;
        addr     = '0;
        wdata    = '0;
        be       = '0;
        id       = '0;
        barrier  = '0;
        mismatch = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_r_valid", 32'(r_valid), 32'd0);
        check("reset_mode",    32'(mode),    32'd0);
        check("reset_irq",     32'(irq),     32'd0);
        check("reset_r_id",    32'(r_id),    32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Reset values readable over the bus.
        rd(A_ACTIVE, 5'd1, 32'd0);
        rd(A_CNT3,   5'd2, 32'd0);
        check("mode_after_reset", 32'(mode), 32'd0);

        // Staging without a barrier does not apply.
        wr(A_CTRL, 32'h5, 4'hF, 5'd3);
        rd(A_ACTIVE, 5'd4, 32'd0);
        rd(A_CTRL,   5'd5, 32'h5);

        // Commit barrier.
        barrier = 8'h01;
        idle(1);
        barrier = 8'h00;
        check("mode_after_commit", 32'(mode), 32'h5);
        rd(A_ACTIVE, 5'd6, 32'h5);

        // Mismatches: pair 0 active, pair 1 inactive.
        mismatch = 4'b0011;
        idle(3);
        mismatch = 4'b0000;
        rd(A_CNT0,   5'd7, 32'd3);
        rd(A_CNT1,   5'd8, 32'd0);
        rd(A_STATUS, 5'd9, 32'h1);
        check("irq_masked", 32'(irq), 32'd0);

        // Enable interrupt: irq follows one cycle after IRQ_EN updates.
        wr(A_IRQEN, 32'h1, 4'hF, 5'd10);
        idle(1);
        check("irq_set", 32'(irq), 32'd1);

        // W1C STATUS: irq drops two cycles after the write request.
        wr(A_STATUS, 32'h1, 4'hF, 5'd11);
        check("irq_still_set", 32'(irq), 32'd1);
        idle(1);
        check("irq_cleared", 32'(irq), 32'd0);

        // Saturation: 3 + 20 counted mismatches clamp at 15.
        mismatch = 4'b0001;
        idle(20);
        mismatch = 4'b0000;
        rd(A_CNT0, 5'd12, 32'd15);

        // Write-clear racing a counted mismatch leaves the count at 1.
        mismatch = 4'b0001;
        wr(A_CNT0, 32'h0, 4'hF, 5'd13);
        mismatch = 4'b0000;
        rd(A_CNT0, 5'd14, 32'd1);

        // W1C racing a new mismatch: set wins.
        mismatch = 4'b0001;
        wr(A_STATUS, 32'h1, 4'hF, 5'd15);
        mismatch = 4'b0000;
        rd(A_STATUS, 5'd16, 32'h1);
        rd(A_CNT0,   5'd17, 32'd2);

        // W1C with byte lane disabled does nothing; enabled lane clears.
        wr(A_STATUS, 32'h1, 4'h0, 5'd18);
        rd(A_STATUS, 5'd19, 32'h1);
        wr(A_STATUS, 32'hF, 4'h1, 5'd20);
        rd(A_STATUS, 5'd21, 32'h0);

        // Unmapped and misaligned accesses.
        bus(1'b1, BASE + 32'h40, 32'd0,  4'h0, 5'd22, 1'b1, 32'd0);
        bus(1'b1, BASE + 32'h02, 32'd0,  4'h0, 5'd23, 1'b1, 32'd0);
        bus(1'b1, BASE - 32'h04, 32'd0,  4'h0, 5'd24, 1'b1, 32'd0);
        bus(1'b0, BASE + 32'h20, 32'hF,  4'hF, 5'd25, 1'b1, 32'd0);
        bus(1'b0, BASE + 32'h01, 32'hF,  4'hF, 5'd26, 1'b1, 32'd0);
        rd(A_CTRL, 5'd27, 32'h5);

        // Byte enables on CTRL.
        wr(A_CTRL, 32'hFF, 4'h0, 5'd28);
        rd(A_CTRL, 5'd29, 32'h5);
        wr(A_CTRL, 32'hFF, 4'h1, 5'd30);
        rd(A_CTRL, 5'd31, 32'hF);
        rd(A_ACTIVE, 5'd1, 32'h5);

        // Back-to-back requests, ids 3 then 7.
        rd(A_ACTIVE, 5'd3, 32'h5);
        rd(A_IRQEN,  5'd7, 32'h1);

        // Commit racing a CTRL write: ACTIVE takes the pre-write CTRL.
        barrier = 8'h01;
        wr(A_CTRL, 32'h3, 4'hF, 5'd2);
        barrier = 8'h00;
        check("commit_prewrite", 32'(mode), 32'hF);
        rd(A_CTRL,   5'd4, 32'h3);
        rd(A_ACTIVE, 5'd5, 32'hF);

        // Non-commit barrier bits are ignored.
        barrier = 8'hFE;
        idle(1);
        barrier = 8'h00;
        check("other_barrier_bits", 32'(mode), 32'hF);
        barrier = 8'h01;
        idle(1);
        barrier = 8'h00;
        check("commit_again", 32'(mode), 32'h3);

        // Inactive pairs ignore mismatches; pair 1 now counts.
        mismatch = 4'b1100;
        idle(2);
        mismatch = 4'b0010;
        idle(1);
        mismatch = 4'b0000;
        rd(A_CNT3,   5'd6, 32'd0);
        rd(A_CNT2,   5'd8, 32'd0);
        rd(A_CNT1,   5'd9, 32'd1);
        rd(A_STATUS, 5'd10, 32'h2);
        check("irq_masked_pair1", 32'(irq), 32'd0);

        // Reset in the middle of a transaction drops the response.
        req  = 1'b1;
        wen  = 1'b1;
        addr = A_CTRL;
        id   = 5'd9;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("pending_valid", 32'(r_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_valid", 32'(r_valid), 32'd0);
        check("reset_drops_id",    32'(r_id),    32'd0);
        check("reset_mode_mid",    32'(mode),    32'd0);
        check("reset_irq_mid",     32'(irq),     32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd(A_CTRL,   5'd11, 32'd0);
        rd(A_STATUS, 5'd12, 32'd0);
        rd(A_CNT1,   5'd13, 32'd0);
        rd(A_CNT0,   5'd14, 32'd0);

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
